// File: rtl/toggle_req_rx.sv
// -----------------------------------------------------------------------------
// toggle_req_rx
//
// Receiving end of a two-phase toggle handshake. The sender flips i_req_tog
// once per data word. This block synchronises that toggle into i_clk, turns
// each level change into a single request, captures i_data, and offers the
// word to local logic on a valid/ready interface. When the word is consumed,
// the block flips o_ack_tog so the sender may present the next word.
//
// Ports
//   i_clk      receiver clock; all state changes on the rising edge
//   i_rst_n    asynchronous, active-low reset
//   i_req_tog  request toggle from the sender domain (asynchronous)
//   i_data     sender data; stable from its toggle until o_ack_tog answers
//   o_ack_tog  acknowledge toggle returned to the sender
//   o_valid    o_data holds a word that has not yet been consumed
//   o_data     captured word
//   i_ready    consumer accepts the word when o_valid and i_ready are both 1
//   o_busy     a transfer is in progress and has not been acknowledged yet
//   o_err_cnt  saturating count of toggles that arrived before the ack
//
// SYNC_STAGES must lie in the range 2..4.
// -----------------------------------------------------------------------------
module toggle_req_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_tog,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ack_tog,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic              o_busy,
    output logic [ERR_W-1:0]  o_err_cnt
);

    // ST_LOAD is the single cycle between capturing the word and raising
    // o_valid. That cycle gives a total latency of SYNC_STAGES+1 cycles, from
    // the first sample of the new request level to o_valid.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Synchroniser chain and edge-history flop.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   req_edge;

    // Handshake state.
    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic                   busy_q,  busy_d;
    logic                   ack_q,   ack_d;
    logic [DATA_W-1:0]      data_q,  data_d;
    logic [ERR_W-1:0]       err_q,   err_d;

    logic                   accept;

    // An edge is any difference between the synchronised level and the level
    // seen one cycle earlier. The history flop follows the last stage every
    // cycle, so an edge is consumed even when it is dropped as a violation.
    // Because of this, a dropped request never comes back later.
    assign req_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign accept   = valid_q & i_ready;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_req_tog};
        hist_d  = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ack_d   = ack_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_edge) begin
                    data_d  = i_data;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                // o_valid is only ever high in this state. Because of that,
                // i_ready has no effect anywhere else.
                if (accept) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Any edge outside IDLE means the sender toggled before it saw the
        // acknowledge. This includes an edge in the same cycle as an accept.
        // The request is dropped: no capture and no extra ack. Only the error
        // count moves, and it saturates.
        if (req_edge && (state_q != ST_IDLE) && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // NOTE: the state register uses non-blocking assignments only. Every flop
    // samples its _d value from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign o_ack_tog = ack_q;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_busy    = busy_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_toggle_req_rx.sv
// -----------------------------------------------------------------------------
// tb_toggle_req_rx
//
// Directed testbench for toggle_req_rx with default parameters (DATA_W=8,
// SYNC_STAGES=2, ERR_W=8). Inputs change 1 ns after a rising edge. Outputs are
// read at the same point, so each read shows the result of the edge just
// passed.
// -----------------------------------------------------------------------------
module tb_toggle_req_rx;

    localparam int DATA_W = 8;
    localparam int ERR_W  = 8;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_req_tog;
    logic [DATA_W-1:0] i_data;
    logic              o_ack_tog;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_ready;
    logic              o_busy;
    logic [ERR_W-1:0]  o_err_cnt;

    int total = 0;
    int bad   = 0;

    toggle_req_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .ERR_W       (ERR_W)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req_tog (i_req_tog),
        .i_data    (i_data),
        .o_ack_tog (o_ack_tog),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_busy    (o_busy),
        .o_err_cnt (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Wait for o_valid, giving up after a fixed number of cycles. Running out
    // of cycles counts as a failed check.
    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        while (o_valid !== 1'b1 && cycles < 20) begin
            step(1);
            cycles++;
        end
        if (o_valid !== 1'b1) check({tag, "_timeout"}, 32'(o_valid), 32'd1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        i_data    = d;
        i_req_tog = ~i_req_tog;
    endtask

    initial begin : stim
        int cyc;
        int words;
        logic exp_ack;

        i_rst_n   = 1'b0;
        i_req_tog = 1'b0;
        i_data    = '0;
        i_ready   = 1'b0;
        step(3);

        // ---- reset state ----
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_ack",   32'(o_ack_tog), 32'd0);
        check("rst_data",  32'(o_data), 32'd0);
        check("rst_err",   32'(o_err_cnt), 32'd0);
        i_rst_n = 1'b1;
        step(2);
        check("idle_valid", 32'(o_valid), 32'd0);

        // ---- single transfer, three-cycle latency ----
        i_ready = 1'b1;
        send(8'hA5);
        step(3);
        check("t1_valid_early", 32'(o_valid), 32'd0);
        step(1);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_data",  32'(o_data), 32'hA5);
        check("t1_busy",  32'(o_busy), 32'd1);
        check("t1_ack_pre", 32'(o_ack_tog), 32'd0);
        step(1);
        check("t1_valid_1cyc", 32'(o_valid), 32'd0);
        check("t1_ack", 32'(o_ack_tog), 32'd1);
        check("t1_busy_off", 32'(o_busy), 32'd0);
        check("t1_err", 32'(o_err_cnt), 32'd0);

        // ---- consumer stall ----
        i_ready = 1'b0;
        send(8'h3C);
        wait_valid("t2", cyc);
        check("t2_data", 32'(o_data), 32'h3C);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t2_hold_valid", 32'(o_valid), 32'd1);
            check("t2_hold_data", 32'(o_data), 32'h3C);
            check("t2_hold_ack", 32'(o_ack_tog), 32'd1);
            check("t2_hold_busy", 32'(o_busy), 32'd1);
        end
        i_ready = 1'b1;
        step(1);
        check("t2_valid_off", 32'(o_valid), 32'd0);
        check("t2_busy_off", 32'(o_busy), 32'd0);
        check("t2_ack", 32'(o_ack_tog), 32'd0);

        // ---- back-to-back stream 0x00..0x0F ----
        exp_ack = 1'b0;
        words   = 0;
        for (int w = 0; w < 16; w++) begin
            send(DATA_W'(w));
            wait_valid("t3", cyc);
            if (o_valid === 1'b1) words++;
            check("t3_data", 32'(o_data), 32'(w));
            exp_ack = ~exp_ack;
            step(1);
            check("t3_ack", 32'(o_ack_tog), 32'(exp_ack));
        end
        check("t3_words", 32'(words), 32'd16);
        check("t3_ack_end", 32'(o_ack_tog), 32'd0);
        check("t3_err", 32'(o_err_cnt), 32'd0);

        // ---- single violation: second toggle while the first word is held ----
        i_ready = 1'b0;
        send(8'h11);
        wait_valid("t4", cyc);
        send(8'h22);
        step(3);
        check("t4_err", 32'(o_err_cnt), 32'd1);
        check("t4_data", 32'(o_data), 32'h11);
        check("t4_valid", 32'(o_valid), 32'd1);
        check("t4_ack_pre", 32'(o_ack_tog), 32'd0);
        i_ready = 1'b1;
        step(1);
        check("t4_ack", 32'(o_ack_tog), 32'd1);
        check("t4_valid_off", 32'(o_valid), 32'd0);
        step(8);
        check("t4_no_replay", 32'(o_valid), 32'd0);
        check("t4_one_ack", 32'(o_ack_tog), 32'd1);

        // ---- edge detected in the same cycle as the accept ----
        i_ready = 1'b0;
        send(8'h5A);
        wait_valid("t5", cyc);
        send(8'h6B);
        step(2);           // the edge is now visible and decoded before the next clock
        i_ready = 1'b1;
        step(1);
        check("t5_err", 32'(o_err_cnt), 32'd2);
        check("t5_ack", 32'(o_ack_tog), 32'd0);
        check("t5_valid_off", 32'(o_valid), 32'd0);
        check("t5_busy_off", 32'(o_busy), 32'd0);
        step(8);
        check("t5_no_valid", 32'(o_valid), 32'd0);
        check("t5_ack_stable", 32'(o_ack_tog), 32'd0);

        // ---- saturation: 300 violating toggles while a word is held ----
        i_ready = 1'b0;
        send(8'h99);
        wait_valid("t6", cyc);
        for (int i = 0; i < 252; i++) begin
            i_req_tog = ~i_req_tog;
            step(1);
        end
        step(3);
        check("t6_err_254", 32'(o_err_cnt), 32'd254);
        i_req_tog = ~i_req_tog;
        step(4);
        check("t6_err_255", 32'(o_err_cnt), 32'd255);
        for (int i = 0; i < 47; i++) begin
            i_req_tog = ~i_req_tog;
            step(1);
        end
        step(3);
        check("t6_err_sat", 32'(o_err_cnt), 32'd255);
        check("t6_data", 32'(o_data), 32'h99);
        i_ready = 1'b1;
        step(1);
        check("t6_ack", 32'(o_ack_tog), 32'd1);
        check("t6_valid_off", 32'(o_valid), 32'd0);

        // ---- asynchronous reset while a word is held ----
        i_ready = 1'b0;
        send(8'h77);
        wait_valid("t7", cyc);
        check("t7_data", 32'(o_data), 32'h77);
        #3;                // mid-cycle, away from any clock edge
        i_rst_n   = 1'b0;
        i_req_tog = 1'b0;
        #1;
        check("t7_valid", 32'(o_valid), 32'd0);
        check("t7_busy", 32'(o_busy), 32'd0);
        check("t7_ack", 32'(o_ack_tog), 32'd0);
        check("t7_data0", 32'(o_data), 32'd0);
        check("t7_err", 32'(o_err_cnt), 32'd0);
        step(2);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        step(10);
        check("t7_no_valid", 32'(o_valid), 32'd0);
        check("t7_ack_after", 32'(o_ack_tog), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
